// File: rtl/waveform_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// PKG_WaveformAnalyzer : shared FSM type, default widths and mid-scale helper
// Revision: 1.0
// ============================================================================
package PKG_WaveformAnalyzer;

  localparam int SAMPLE_W = 12;
  localparam int PERIOD_W = 16;
  localparam int HYST     = 64;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  function automatic int mid(input int w);
    return 1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/waveform_analyzer_if.sv
`default_nettype none
// ============================================================================
// waveform_analyzer_if : sample stream in, measurement results out
// Revision: 1.0
// ============================================================================
interface waveform_analyzer_if #(
  parameter int SAMPLE_W = PKG_WaveformAnalyzer::SAMPLE_W,
  parameter int PERIOD_W = PKG_WaveformAnalyzer::PERIOD_W
);
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic [PERIOD_W-1:0] period;
  logic [SAMPLE_W-1:0] min_val;
  logic [SAMPLE_W-1:0] max_val;
  logic                result_valid;
  logic                result_ready;
  logic                no_signal;
  logic                overrun;

  modport master (
    output sample, sample_valid, result_ready,
    input  period, min_val, max_val, result_valid, no_signal, overrun
  );

  modport slave (
    input  sample, sample_valid, result_ready,
    output period, min_val, max_val, result_valid, no_signal, overrun
  );
endinterface
`default_nettype wire

// File: rtl/waveform_analyzer_crossing_detector.sv
`default_nettype none
// ============================================================================
// crossing_detector : hysteresis comparator around mid-scale with level flag
// Revision: 1.0
// ============================================================================
module crossing_detector #(
  parameter int SAMPLE_W = PKG_WaveformAnalyzer::SAMPLE_W,
  parameter int HYST     = PKG_WaveformAnalyzer::HYST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_valid,
  output logic                o_is_high,
  output logic                o_is_low,
  output logic                o_level
);
  import PKG_WaveformAnalyzer::*;

  localparam logic [SAMPLE_W-1:0] c_TH_HI = SAMPLE_W'(mid(SAMPLE_W) + HYST);
  localparam logic [SAMPLE_W-1:0] c_TH_LO = SAMPLE_W'(mid(SAMPLE_W) - HYST);

  logic r_level;

  assign o_is_high = (i_sample >= c_TH_HI);
  assign o_is_low  = (i_sample <  c_TH_LO);
  assign o_level   = r_level;

  // Samples inside the dead band leave the level untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
    end else if (i_valid) begin
      if (o_is_high) begin
        r_level <= 1'b1;
      end else if (o_is_low) begin
        r_level <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/waveform_analyzer.sv
`default_nettype none
// ============================================================================
// waveform_analyzer : per-period length and min/max of a 12-bit sample stream
// Revision: 1.0
// ============================================================================
module waveform_analyzer #(
  parameter int SAMPLE_W = PKG_WaveformAnalyzer::SAMPLE_W,
  parameter int PERIOD_W = PKG_WaveformAnalyzer::PERIOD_W,
  parameter int HYST     = PKG_WaveformAnalyzer::HYST
) (
  input  logic              clk,
  input  logic              rst,
  waveform_analyzer_if.slave bus
);
  import PKG_WaveformAnalyzer::*;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [SAMPLE_W-1:0] r_min;
  logic [SAMPLE_W-1:0] r_max;
  logic [PERIOD_W-1:0] r_period;
  logic [SAMPLE_W-1:0] r_min_val;
  logic [SAMPLE_W-1:0] r_max_val;
  logic                r_result_valid;
  logic                r_no_signal;
  logic                r_overrun;

  logic w_is_high;
  logic w_is_low;
  logic w_level;
  logic w_cross;
  logic w_result;
  logic w_timeout;

  crossing_detector #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST)
  ) u_crossing_detector (
    .clk       (clk),
    .rst       (rst),
    .i_sample  (bus.sample),
    .i_valid   (bus.sample_valid),
    .o_is_high (w_is_high),
    .o_is_low  (w_is_low),
    .o_level   (w_level)
  );

  // The first high sample in SEEK also counts as a crossing so it cannot time out.
  assign w_cross   = w_is_high && ((r_state == SEEK) || ((r_state == MEASURE) && !w_level));
  assign w_result  = bus.sample_valid && w_is_high && (r_state == MEASURE) && !w_level;
  assign w_timeout = bus.sample_valid && !w_cross && (r_cnt == {PERIOD_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ARM;
      r_cnt          <= '0;
      r_min          <= '0;
      r_max          <= '0;
      r_period       <= '0;
      r_min_val      <= '0;
      r_max_val      <= '0;
      r_result_valid <= 1'b0;
      r_no_signal    <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_no_signal <= 1'b0;

      // A new result may replace one that is being accepted on this same edge.
      if (w_result) begin
        if (!r_result_valid || bus.result_ready) begin
          r_period       <= r_cnt + 1'b1;
          r_min_val      <= r_min;
          r_max_val      <= r_max;
          r_result_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (bus.result_ready) begin
        r_result_valid <= 1'b0;
      end

      if (bus.sample_valid) begin
        if (w_timeout) begin
          r_no_signal <= 1'b1;
          r_cnt       <= '0;
          r_min       <= '0;
          r_max       <= '0;
          r_state     <= ARM;
        end else begin
          case (r_state)
            ARM: begin
              r_cnt <= r_cnt + 1'b1;
              if (w_is_low) begin
                r_state <= SEEK;
              end
            end
            SEEK: begin
              if (w_is_high) begin
                r_cnt   <= '0;
                r_min   <= bus.sample;
                r_max   <= bus.sample;
                r_state <= MEASURE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            MEASURE: begin
              if (w_cross) begin
                r_cnt <= '0;
                r_min <= bus.sample;
                r_max <= bus.sample;
              end else begin
                r_cnt <= r_cnt + 1'b1;
                if (bus.sample < r_min) begin
                  r_min <= bus.sample;
                end
                if (bus.sample > r_max) begin
                  r_max <= bus.sample;
                end
              end
            end
            default: begin
              r_state <= ARM;
            end
          endcase
        end
      end
    end
  end

  assign bus.period       = r_period;
  assign bus.min_val      = r_min_val;
  assign bus.max_val      = r_max_val;
  assign bus.result_valid = r_result_valid;
  assign bus.no_signal    = r_no_signal;
  assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/waveform_analyzer.md
# waveform_analyzer

Receive-side counterpart of the function generator: consumes a stream of 12-bit samples (an ADC capture, or the generator output looped back) and measures the waveform. It finds rising crossings of mid-scale with hysteresis and reports, per period, the period length in samples plus the minimum and maximum sample values. Results leave through a valid/ready handshake to the host or test logic.

## Interface
- `SAMPLE_W`, 12: sample width.
- `PERIOD_W`, 16: width of the period counter and of the `period` result.
- `HYST`, 64: hysteresis half-band around mid-scale `1 << (SAMPLE_W-1)` (0x800).
- `clk`  in  1: sole clock; every register updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `sample`  in  SAMPLE_W: unsigned sample value.
- `sample_valid`  in  1: `sample` is consumed on an edge where this is high; there is no backpressure.
- `period`  out  PERIOD_W: samples between two consecutive rising crossings.
- `min_val`  out  SAMPLE_W: minimum sample in the measured period.
- `max_val`  out  SAMPLE_W: maximum sample in the measured period.
- `result_valid`  out  1: `period`/`min_val`/`max_val` hold an unconsumed result.
- `result_ready`  in  1: consumer accepts the result on an edge where `result_valid && result_ready`.
- `no_signal`  out  1: one-cycle pulse when the timeout counter saturates.
- `overrun`  out  1: sticky; a result was dropped because the previous one was unconsumed.

## Operation
- Thresholds: `TH_HI = 0x800 + HYST`, `TH_LO = 0x800 - HYST`. A sample is "high" if `>= TH_HI` and "low" if `< TH_LO`.
- State machine `ARM`, `SEEK`, `MEASURE`. Only edges with `sample_valid` high advance any state; other edges hold everything except handshake clearing.
- `ARM` (reset state): wait for a low sample, then go to `SEEK`. This guarantees the first crossing is a genuine low-to-high transition.
- `SEEK`: wait for a high sample. That sample is the rising crossing:
  - set `cnt` to 0;
  - load both `min_r` and `max_r` with the sample;
  - go to `MEASURE` with the level marked high.
- `MEASURE` tracks the level with hysteresis. A low sample marks the level low; a high sample while the level is low is the next rising crossing.
  - On a non-crossing sample: `cnt++`, then update `min_r`/`max_r`.
  - On a crossing sample:
    - form the result `period = cnt + 1`, with `min_r`/`max_r` computed over the period's samples (the starting crossing sample is included, the ending one excluded);
    - restart `cnt` at 0 and reload `min_r`/`max_r` with the crossing sample;
    - stay in `MEASURE`.
- Result register handling when a result is formed:
  - `result_valid` low, or `result_ready` high on the same edge: load the new result and set `result_valid` to 1.
  - Otherwise: drop the new result, keep the old one, and set `overrun` to 1.
- Timeout:
  - `cnt` also counts valid samples in `ARM` and `SEEK`.
  - When a valid sample arrives with `cnt == 2^PERIOD_W - 1` and no crossing:
    - pulse `no_signal`;
    - set `cnt` to 0, clear the min/max trackers, and go to `ARM`.
  - A pending result is unaffected.
- Arithmetic: all compares are unsigned. `cnt` never wraps, because the timeout fires first.

## Timing
- Reset values: `period = 0`, `min_val = 0`, `max_val = 0`, `result_valid = 0`, `no_signal = 0`, `overrun = 0`; state `ARM`, level low, `cnt = 0`.
- Latency: the result is visible, with `result_valid` high, in the cycle after the edge that consumed the crossing sample.
- Result outputs are stable while `result_valid` is high and unconsumed.
- `result_valid` falls on the accept edge unless a new result loads on that same edge.
- `no_signal` is high for exactly one cycle, the one after the timeout edge.
- Reset asserted mid-period discards the partial measurement and any pending result. The first result after reset needs an `ARM` → `SEEK` → crossing → crossing sequence.
- Maximum input rate is one sample per clock.

## Structure
- Package `PKG_WaveformAnalyzer`:
  - `typedef enum { ARM, SEEK, MEASURE } state_t`;
  - default constants `SAMPLE_W`, `PERIOD_W`, `HYST`;
  - function `mid(w)` returning `1 << (w-1)`.
- Sub-module `crossing_detector`: the hysteresis comparator. It takes sample, valid, clk and rst, and outputs `is_high`, `is_low` and the registered level. The top-level FSM combines these with its state.

## Test plan
- Sawtooth 0..0xFFF, wrapping, one sample per clock, `result_ready` tied high → first result after the second crossing at 0x840: `period = 4096`, `min_val = 0x000`, `max_val = 0xFFF`, then one result every 4096 cycles.
- Triangle 0→0xFFF→0, step 1 → `period = 8190`, `min_val = 0`, `max_val = 0xFFF`.
- Square wave, 16 samples at 0x000 then 16 at 0xFFF, with `sample_valid` high every other clock → `period = 32`, one result every 64 clocks.
- Constant 0x800 input → `result_valid` never rises; `no_signal` pulses every 65536 valid samples.
- Square wave with `period = 32` and `result_ready` held low → first result held; the second result is dropped and `overrun` goes to 1. Raising `result_ready` for one cycle clears `result_valid`; `overrun` stays 1.
- Reset pulse asserted 10 samples into a sawtooth period with a result pending → all outputs return to 0 immediately. The next result is reported after two further crossings, with `period = 4096`.
